// File: rtl/branch_killable_queue_mw_pkg.sv
// Shared LSU types for the branch-killable request queue.
// Uop, branch-update and DCache request bundles plus kill helpers.
package branch_killable_queue_mw_pkg;

  localparam int MAX_BR_COUNT = 4;

  typedef logic [MAX_BR_COUNT-1:0] br_mask_t;

  typedef struct packed {
    logic [7:0] uopc;
    br_mask_t   br_mask;
    logic       uses_ldq;
    logic [4:0] ldq_idx;
  } MicroOpST;

  typedef struct packed {
    br_mask_t resolve_mask;
    br_mask_t mispredict_mask;
  } BrUpdateB1ST;

  typedef struct packed {
    BrUpdateB1ST b1;
  } BrUpdateInfoST;

  typedef struct packed {
    MicroOpST    uop;
    logic [15:0] addr;
    logic [31:0] data;
  } BoomDCacheReqInternalST;

  function automatic br_mask_t getNewBrMask(
    input BrUpdateInfoST b,
    input br_mask_t      m
  );
    return m & ~b.b1.resolve_mask;
  endfunction

  function automatic logic maskMatch(
    input br_mask_t a,
    input br_mask_t b
  );
    return |(a & b);
  endfunction

  function automatic logic isKilledByBranch(
    input BrUpdateInfoST b,
    input br_mask_t      m
  );
    return maskMatch(b.b1.mispredict_mask, m);
  endfunction

endpackage

// File: rtl/branch_killable_queue_mw_compactor.sv
// Enqueue lane compactor: per-lane slot offsets and total lane count.
// Offset of lane k is the number of valid lanes below it.
module bkq_enq_compactor #(
  parameter int ENQ_WIDTH = 2,
  parameter int OW        = $clog2(ENQ_WIDTH + 1)
) (
  input  logic [ENQ_WIDTH-1:0] i_valid,
  output logic [OW-1:0]        o_offset [ENQ_WIDTH],
  output logic [OW-1:0]        o_total
);

  // running prefix popcount over the lanes
  always_comb begin
    logic [OW-1:0] acc;
    acc = '0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      o_offset[k] = acc;
      acc = acc + OW'(i_valid[k]);
    end
    o_total = acc;
  end

endmodule

// File: rtl/branch_killable_queue_mw.sv
// Multi-lane branch-killable circular queue for LSU -> DCache requests.
// Dead slots are reclaimed at the head; optional empty-queue bypass.
module branch_killable_queue_mw
  import branch_killable_queue_mw_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int ENQ_WIDTH = 2,
  parameter int FLOW      = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ENQ_WIDTH-1:0]   i_enq_valid,
  input  BoomDCacheReqInternalST i_enq [ENQ_WIDTH],
  output logic                   o_enq_ready,
  output logic                   o_deq_valid,
  output BoomDCacheReqInternalST o_deq,
  input  logic                   i_deq_ready,
  input  BrUpdateInfoST          i_brupdate,
  input  logic                   i_flush,
  output logic                   o_empty,
  output logic [$clog2(ENTRIES+1)-1:0] o_count
);

  localparam int PW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);
  localparam int OW = $clog2(ENQ_WIDTH + 1);
  localparam int LW = (ENQ_WIDTH > 1) ? $clog2(ENQ_WIDTH) : 1;

  BoomDCacheReqInternalST ram   [ENTRIES];
  br_mask_t               masks [ENTRIES];
  logic [ENTRIES-1:0]     valids;
  logic [PW-1:0]          enq_ptr;
  logic [PW-1:0]          deq_ptr;
  logic                   maybe_full;

  BoomDCacheReqInternalST lane_req   [ENQ_WIDTH];
  logic [ENQ_WIDTH-1:0]   lane_alive;
  logic [ENQ_WIDTH-1:0]   eff_valid;
  logic [OW-1:0]          offs [ENQ_WIDTH];
  logic [OW-1:0]          total;
  logic [PW-1:0]          slot [ENQ_WIDTH];
  logic [LW-1:0]          low_lane;
  BoomDCacheReqInternalST head;
  logic                   head_kill;
  logic                   q_deq_valid;
  logic                   q_deq_fire;
  logic                   byp_active;
  logic                   byp_valid;
  logic                   byp_fire;
  logic                   reclaim;
  logic                   deq_adv;
  logic                   enq_fire;
  logic                   ptr_match;
  logic [OW-1:0]          n_enq;
  logic [OW-1:0]          n_deq;

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] p,
    input logic [OW-1:0] n
  );
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(ENTRIES)) s = s - (PW+1)'(ENTRIES);
    return s[PW-1:0];
  endfunction

  bkq_enq_compactor #(
    .ENQ_WIDTH(ENQ_WIDTH),
    .OW       (OW)
  ) u_compactor (
    .i_valid (eff_valid),
    .o_offset(offs),
    .o_total (total)
  );

  // occupancy, readiness and head view with this cycle's branch update
  always_comb begin
    ptr_match = (enq_ptr == deq_ptr);
    o_empty   = ptr_match & ~maybe_full;
    if (ptr_match)
      o_count = maybe_full ? CW'(ENTRIES) : '0;
    else if (enq_ptr > deq_ptr)
      o_count = CW'(enq_ptr) - CW'(deq_ptr);
    else
      o_count = CW'(ENTRIES) + CW'(enq_ptr) - CW'(deq_ptr);
    o_enq_ready = (CW'(ENTRIES) - o_count) >= CW'(ENQ_WIDTH);

    head = ram[deq_ptr];
    head.uop.br_mask = getNewBrMask(i_brupdate, masks[deq_ptr]);
    head_kill = isKilledByBranch(i_brupdate, masks[deq_ptr])
              | (i_flush & ram[deq_ptr].uop.uses_ldq);
    q_deq_valid = ~o_empty & valids[deq_ptr] & ~head_kill;
    reclaim = ~o_empty & ~valids[deq_ptr];
  end

  // incoming lanes: updated masks, liveness and lowest valid lane
  always_comb begin
    low_lane = '0;
    for (int k = ENQ_WIDTH - 1; k >= 0; k--) begin
      lane_req[k] = i_enq[k];
      lane_req[k].uop.br_mask =
        getNewBrMask(i_brupdate, i_enq[k].uop.br_mask);
      lane_alive[k] =
        ~isKilledByBranch(i_brupdate, i_enq[k].uop.br_mask)
        & ~(i_flush & i_enq[k].uop.uses_ldq);
      if (i_enq_valid[k]) low_lane = LW'(k);
    end
  end

  // dequeue select, bypass steering and enqueue slot assignment
  always_comb begin
    byp_active = (FLOW != 0) & o_empty & (|i_enq_valid);
    byp_valid  = byp_active & lane_alive[low_lane];
    byp_fire   = byp_valid & i_deq_ready;
    o_deq_valid = byp_active ? byp_valid : q_deq_valid;
    o_deq       = byp_active ? lane_req[low_lane] : head;
    q_deq_fire  = q_deq_valid & i_deq_ready;
    deq_adv     = q_deq_fire | reclaim;

    eff_valid = i_enq_valid
              & ~(byp_fire ? (ENQ_WIDTH'(1) << low_lane) : '0);
    enq_fire  = o_enq_ready & (|eff_valid);
    n_enq     = enq_fire ? total : '0;
    n_deq     = OW'(deq_adv);
    for (int k = 0; k < ENQ_WIDTH; k++)
      slot[k] = wrap_add(enq_ptr, offs[k]);
  end

  // pointers, maybe_full and per-entry liveness
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
      valids     <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++)
        if (valids[i] &&
            (isKilledByBranch(i_brupdate, masks[i]) ||
             (i_flush && ram[i].uop.uses_ldq)))
          valids[i] <= 1'b0;
      if (q_deq_fire) valids[deq_ptr] <= 1'b0;
      if (enq_fire) begin
        for (int k = 0; k < ENQ_WIDTH; k++)
          if (eff_valid[k]) valids[slot[k]] <= lane_alive[k];
        enq_ptr <= wrap_add(enq_ptr, total);
      end
      if (deq_adv) deq_ptr <= wrap_add(deq_ptr, OW'(1));
      if (n_enq > n_deq)      maybe_full <= 1'b1;
      else if (n_enq < n_deq) maybe_full <= 1'b0;
    end
  end

  // payload and branch-mask storage (not reset)
  always_ff @(posedge clock) begin
    for (int i = 0; i < ENTRIES; i++)
      masks[i] <= getNewBrMask(i_brupdate, masks[i]);
    if (enq_fire)
      for (int k = 0; k < ENQ_WIDTH; k++)
        if (eff_valid[k]) begin
          ram[slot[k]]   <= i_enq[k];
          masks[slot[k]] <= lane_req[k].uop.br_mask;
        end
  end

endmodule

// File: tb/tb_branch_killable_queue_mw.sv
// Directed bench for branch_killable_queue_mw.
// Queue instance (FLOW=0) and bypass instance (FLOW=1), depth 5, 2 lanes.
module tb_branch_killable_queue_mw;
  import branch_killable_queue_mw_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]             a_valid;
  BoomDCacheReqInternalST a_enq [2];
  logic                   a_ready;
  logic                   a_deq_valid;
  BoomDCacheReqInternalST a_deq;
  logic                   a_deq_ready;
  BrUpdateInfoST          a_br;
  logic                   a_flush;
  logic                   a_empty;
  logic [2:0]             a_count;

  logic [1:0]             b_valid;
  BoomDCacheReqInternalST b_enq [2];
  logic                   b_ready;
  logic                   b_deq_valid;
  BoomDCacheReqInternalST b_deq;
  logic                   b_deq_ready;
  BrUpdateInfoST          b_br;
  logic                   b_flush;
  logic                   b_empty;
  logic [2:0]             b_count;

  int checks = 0;
  int errors = 0;

  branch_killable_queue_mw #(
    .ENTRIES(5), .ENQ_WIDTH(2), .FLOW(0)
  ) dut (
    .clock(clock), .reset(reset),
    .i_enq_valid(a_valid), .i_enq(a_enq),
    .o_enq_ready(a_ready), .o_deq_valid(a_deq_valid),
    .o_deq(a_deq), .i_deq_ready(a_deq_ready),
    .i_brupdate(a_br), .i_flush(a_flush),
    .o_empty(a_empty), .o_count(a_count)
  );

  branch_killable_queue_mw #(
    .ENTRIES(5), .ENQ_WIDTH(2), .FLOW(1)
  ) dut_f (
    .clock(clock), .reset(reset),
    .i_enq_valid(b_valid), .i_enq(b_enq),
    .o_enq_ready(b_ready), .o_deq_valid(b_deq_valid),
    .o_deq(b_deq), .i_deq_ready(b_deq_ready),
    .i_brupdate(b_br), .i_flush(b_flush),
    .o_empty(b_empty), .o_count(b_count)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic BoomDCacheReqInternalST mk(
    input logic [15:0] addr,
    input br_mask_t    bm,
    input logic        ldq
  );
    BoomDCacheReqInternalST r;
    r = '0;
    r.addr = addr;
    r.data = {16'h0, addr};
    r.uop.br_mask  = bm;
    r.uop.uses_ldq = ldq;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_idle();
    a_valid = 2'b00;
    a_enq[0] = '0;
    a_enq[1] = '0;
  endtask

  initial begin
    a_idle();
    a_deq_ready = 1'b0;
    a_br = '0;
    a_flush = 1'b0;
    b_valid = 2'b00;
    b_enq[0] = '0;
    b_enq[1] = '0;
    b_deq_ready = 1'b0;
    b_br = '0;
    b_flush = 1'b0;

    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_empty", a_empty, 1);
    check("rst_count", a_count, 0);
    check("rst_deqv", a_deq_valid, 0);
    check("rst_ready", a_ready, 1);

    // fill two lanes per cycle
    a_valid = 2'b11;
    a_enq[0] = mk(16'h1, 4'b0, 1'b0);
    a_enq[1] = mk(16'h2, 4'b0, 1'b0);
    #1;
    check("fill_lat", a_deq_valid, 0);
    tick();
    a_enq[0] = mk(16'h3, 4'b0, 1'b0);
    a_enq[1] = mk(16'h4, 4'b0, 1'b0);
    tick();
    a_idle();
    #1;
    check("fill_cnt", a_count, 4);
    check("fill_rdy", a_ready, 0);
    a_deq_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_v", a_deq_valid, 1);
      check("drain_a", a_deq.addr, 64'(i));
      tick();
    end
    check("drain_e", a_empty, 1);

    // wrap enq_ptr 4 -> 0
    a_deq_ready = 1'b0;
    a_valid = 2'b11;
    a_enq[0] = mk(16'h5, 4'b0, 1'b0);
    a_enq[1] = mk(16'h6, 4'b0, 1'b0);
    tick();
    a_idle();
    a_deq_ready = 1'b1;
    #1;
    check("wrap_cnt", a_count, 2);
    check("wrap_a5", a_deq.addr, 16'h5);
    tick();
    check("wrap_a6", a_deq.addr, 16'h6);
    tick();
    check("wrap_e", a_empty, 1);

    // only lane 1 valid
    a_deq_ready = 1'b0;
    a_valid = 2'b10;
    a_enq[0] = mk(16'hBB, 4'b0, 1'b0);
    a_enq[1] = mk(16'hA, 4'b0, 1'b0);
    tick();
    a_idle();
    #1;
    check("l1_cnt", a_count, 1);
    check("l1_v", a_deq_valid, 1);
    check("l1_a", a_deq.addr, 16'hA);
    a_deq_ready = 1'b1;
    tick();
    check("l1_e", a_empty, 1);
    a_deq_ready = 1'b0;

    // mispredict kills three entries, holes reclaimed 1/cycle
    a_valid = 2'b11;
    a_enq[0] = mk(16'h10, 4'b0100, 1'b0);
    a_enq[1] = mk(16'h11, 4'b0100, 1'b0);
    tick();
    a_valid = 2'b01;
    a_enq[0] = mk(16'h12, 4'b0100, 1'b0);
    tick();
    a_idle();
    a_br.b1.mispredict_mask = 4'b0100;
    #1;
    check("mp_same", a_deq_valid, 0);
    tick();
    a_br = '0;
    #1;
    check("mp_c3", a_count, 3);
    check("mp_v", a_deq_valid, 0);
    tick();
    check("mp_c2", a_count, 2);
    tick();
    check("mp_c1", a_count, 1);
    tick();
    check("mp_c0", a_count, 0);
    check("mp_e", a_empty, 1);

    // resolve updates head mask in the same cycle
    a_valid = 2'b01;
    a_enq[0] = mk(16'h20, 4'b0011, 1'b0);
    tick();
    a_idle();
    a_br.b1.resolve_mask = 4'b0001;
    #1;
    check("rs_comb", a_deq.uop.br_mask, 4'b0010);
    tick();
    a_br = '0;
    #1;
    check("rs_store", a_deq.uop.br_mask, 4'b0010);
    a_deq_ready = 1'b1;
    tick();
    check("rs_e", a_empty, 1);
    a_deq_ready = 1'b0;

    // flush kills uses_ldq entries only
    a_valid = 2'b11;
    a_enq[0] = mk(16'h31, 4'b0, 1'b1);
    a_enq[1] = mk(16'h32, 4'b0, 1'b0);
    tick();
    a_valid = 2'b01;
    a_enq[0] = mk(16'h33, 4'b0, 1'b1);
    tick();
    a_idle();
    a_flush = 1'b1;
    a_deq_ready = 1'b1;
    #1;
    check("fl_head", a_deq_valid, 0);
    tick();
    a_flush = 1'b0;
    #1;
    check("fl_c3", a_count, 3);
    check("fl_v0", a_deq_valid, 0);
    tick();
    check("fl_v1", a_deq_valid, 1);
    check("fl_a", a_deq.addr, 16'h32);
    tick();
    check("fl_c1", a_count, 1);
    check("fl_v2", a_deq_valid, 0);
    tick();
    check("fl_e", a_empty, 1);
    a_deq_ready = 1'b0;

    // killed on entry: slot consumed, never delivered
    a_valid = 2'b01;
    a_enq[0] = mk(16'h60, 4'b0100, 1'b0);
    a_br.b1.mispredict_mask = 4'b0100;
    tick();
    a_idle();
    a_br = '0;
    #1;
    check("ek_cnt", a_count, 1);
    check("ek_v", a_deq_valid, 0);
    tick();
    check("ek_c0", a_count, 0);

    // reset mid-fill
    a_valid = 2'b11;
    a_enq[0] = mk(16'h70, 4'b0, 1'b0);
    a_enq[1] = mk(16'h71, 4'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_idle();
    #1;
    check("rm_cnt", a_count, 0);
    check("rm_e", a_empty, 1);
    check("rm_rdy", a_ready, 1);

    // bypass: single lane flows through
    b_valid = 2'b01;
    b_enq[0] = mk(16'h40, 4'b0, 1'b0);
    b_deq_ready = 1'b1;
    #1;
    check("by_v", b_deq_valid, 1);
    check("by_a", b_deq.addr, 16'h40);
    tick();
    b_valid = 2'b00;
    #1;
    check("by_c0", b_count, 0);
    check("by_e", b_empty, 1);

    // bypass lane 0, lane 1 stored
    b_valid = 2'b11;
    b_enq[0] = mk(16'h41, 4'b0, 1'b0);
    b_enq[1] = mk(16'h42, 4'b0, 1'b0);
    #1;
    check("b2_a", b_deq.addr, 16'h41);
    tick();
    b_valid = 2'b00;
    #1;
    check("b2_cnt", b_count, 1);
    check("b2_v", b_deq_valid, 1);
    check("b2_a2", b_deq.addr, 16'h42);
    tick();
    check("b2_e", b_empty, 1);

    // bypass offered but not taken: normal enqueue
    b_deq_ready = 1'b0;
    b_valid = 2'b01;
    b_enq[0] = mk(16'h50, 4'b0, 1'b0);
    #1;
    check("bn_v", b_deq_valid, 1);
    tick();
    b_valid = 2'b00;
    #1;
    check("bn_cnt", b_count, 1);
    check("bn_a", b_deq.addr, 16'h50);
    b_deq_ready = 1'b1;
    tick();
    check("bn_e", b_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
